// File: rtl/pe_seq_ctrl_if.sv
// Signal bundle between pe_seq_ctrl and its environment: run control, instruction
// buffer, shared neuron/weight SRAM, PE tags/results and result buffer.
interface pe_seq_ctrl_if #(
    parameter int unsigned INST_AW = 2,
    parameter int unsigned DATA_AW = 4,
    parameter int unsigned RES_AW  = 2,
    parameter int unsigned RES_W   = 32
);
    logic               start;
    logic [INST_AW:0]   inst_num;
    logic               busy;
    logic               done;
    logic               err;
    logic [INST_AW-1:0] inst_addr;
    logic [7:0]         inst_data;
    logic [DATA_AW-1:0] nw_addr;
    logic               nw_ren;
    logic [1:0]         pe_ctl;
    logic               pe_vld_i;
    logic [RES_W-1:0]   pe_result;
    logic               pe_vld_o;
    logic               res_we;
    logic [RES_AW-1:0]  res_addr;
    logic [RES_W-1:0]   res_wdata;

    modport master (
        input  start, inst_num, inst_data, pe_result, pe_vld_o,
        output busy, done, err, inst_addr, nw_addr, nw_ren, pe_ctl, pe_vld_i,
               res_we, res_addr, res_wdata
    );

    modport slave (
        output start, inst_num, inst_data, pe_result, pe_vld_o,
        input  busy, done, err, inst_addr, nw_addr, nw_ren, pe_ctl, pe_vld_i,
               res_we, res_addr, res_wdata
    );
endinterface

// File: rtl/pe_seq_ctrl.sv
// Sequencer for parallel_pe: walks the instruction buffer, issues shared neuron/weight
// read addresses, tags PE beats in step with SRAM read data and captures PE results.
module pe_seq_ctrl #(
    parameter int unsigned INST_AW = 2,
    parameter int unsigned DATA_AW = 4,
    parameter int unsigned RES_AW  = 2,
    parameter int unsigned RES_W   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    pe_seq_ctrl_if.master bus
);

    localparam int unsigned OUT_W = INST_AW + 2;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StIssue,
        StDrain
    } state_e;

    state_e             state_q, state_d;
    logic [INST_AW:0]   inst_num_q, inst_num_d;
    logic [INST_AW:0]   inst_ptr_q, inst_ptr_d;
    logic [INST_AW:0]   inst_ptr_inc;
    logic [3:0]         beat_cnt_q, beat_cnt_d;
    logic               first_q, first_d;
    logic [DATA_AW-1:0] data_ptr_q, data_ptr_d;
    logic [RES_AW-1:0]  res_ptr_q, res_ptr_d;
    logic [OUT_W-1:0]   outst_q, outst_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               vld_o_q;
    logic               pe_vld_q, pe_vld_d;
    logic [1:0]         pe_ctl_q, pe_ctl_d;

    logic               is_dot, dot_legal, issue_last;
    logic               vld_rise, capture, stray;
    logic [INST_AW-1:0] inst_addr;
    logic [DATA_AW-1:0] nw_addr;
    logic               nw_ren;
    logic [RES_W-1:0]   res_wdata;
    logic               unused_inst_bits;

    assign inst_ptr_inc     = inst_ptr_q + (INST_AW + 1)'(1);
    assign is_dot           = bus.inst_data[7:6] == 2'b01;
    assign dot_legal        = is_dot && (bus.inst_data[3:0] != 4'd0);
    assign unused_inst_bits = ^bus.inst_data[5:4];

    // Only the first cycle of each pe_vld_o high period counts as a result.
    assign vld_rise = bus.pe_vld_o && !vld_o_q;
    assign capture  = vld_rise && (outst_q != '0);
    assign stray    = vld_rise && (outst_q == '0);

    always_comb begin
        state_d    = state_q;
        inst_num_d = inst_num_q;
        inst_ptr_d = inst_ptr_q;
        beat_cnt_d = beat_cnt_q;
        first_d    = first_q;
        data_ptr_d = data_ptr_q;
        res_ptr_d  = res_ptr_q;
        outst_d    = outst_q;
        err_d      = err_q;
        done_d     = 1'b0;
        pe_vld_d   = 1'b0;
        pe_ctl_d   = 2'b00;
        issue_last = 1'b0;
        inst_addr  = '0;
        nw_addr    = '0;
        nw_ren     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    inst_num_d = bus.inst_num;
                    inst_ptr_d = '0;
                    data_ptr_d = '0;
                    res_ptr_d  = '0;
                    outst_d    = '0;
                    err_d      = 1'b0;
                    state_d    = (bus.inst_num == '0) ? StDrain : StFetch;
                end
            end
            StFetch: begin
                inst_addr = inst_ptr_q[INST_AW-1:0];
                state_d   = StDecode;
            end
            StDecode: begin
                inst_ptr_d = inst_ptr_inc;
                if (dot_legal) begin
                    beat_cnt_d = bus.inst_data[3:0];
                    first_d    = 1'b1;
                    state_d    = StIssue;
                end else begin
                    // A single-beat DOT has no distinct first/last tag; flag it and skip.
                    if (is_dot) begin
                        err_d = 1'b1;
                    end
                    state_d = (inst_ptr_inc < inst_num_q) ? StFetch : StDrain;
                end
            end
            StIssue: begin
                nw_ren     = 1'b1;
                nw_addr    = data_ptr_q;
                data_ptr_d = data_ptr_q + DATA_AW'(1);
                pe_vld_d   = 1'b1;
                pe_ctl_d   = {beat_cnt_q == 4'd0, first_q};
                first_d    = 1'b0;
                beat_cnt_d = beat_cnt_q - 4'd1;
                if (beat_cnt_q == 4'd0) begin
                    issue_last = 1'b1;
                    state_d    = (inst_ptr_q < inst_num_q) ? StFetch : StDrain;
                end
            end
            StDrain: begin
                if (outst_q == '0) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (issue_last && !capture) begin
            outst_d = outst_q + OUT_W'(1);
        end else if (capture && !issue_last) begin
            outst_d = outst_q - OUT_W'(1);
        end
        if (capture) begin
            res_ptr_d = res_ptr_q + RES_AW'(1);
        end
        if (stray) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            inst_num_q <= '0;
            inst_ptr_q <= '0;
            beat_cnt_q <= '0;
            first_q    <= 1'b0;
            data_ptr_q <= '0;
            res_ptr_q  <= '0;
            outst_q    <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            vld_o_q    <= 1'b0;
            pe_vld_q   <= 1'b0;
            pe_ctl_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            inst_num_q <= inst_num_d;
            inst_ptr_q <= inst_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            first_q    <= first_d;
            data_ptr_q <= data_ptr_d;
            res_ptr_q  <= res_ptr_d;
            outst_q    <= outst_d;
            err_q      <= err_d;
            done_q     <= done_d;
            vld_o_q    <= bus.pe_vld_o;
            pe_vld_q   <= pe_vld_d;
            pe_ctl_q   <= pe_ctl_d;
        end
    end

    assign res_wdata = capture ? bus.pe_result : '0;

    assign bus.busy      = state_q != StIdle;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.inst_addr = inst_addr;
    assign bus.nw_addr   = nw_addr;
    assign bus.nw_ren    = nw_ren;
    assign bus.pe_ctl    = pe_ctl_q;
    assign bus.pe_vld_i  = pe_vld_q;
    assign bus.res_we    = capture;
    assign bus.res_addr  = res_ptr_q;
    assign bus.res_wdata = res_wdata;

endmodule
